uart_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) that turns a line-level `rx` input into one parallel byte per frame with a single-cycle valid strobe. It is the receive end of the board's UART link: it sits directly behind the FPGA's RX pin and feeds the byte-oriented logic in the design. It runs on the 100 MHz system clock. A bit-period counter recovers each bit at its centre, and a small state machine checks the framing.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. A bit-period counter finds the centre of each
// bit and a five-state FSM checks the framing and emits one-cycle pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] C_FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic [1:0]  r_sync;
  logic [1:0]  r_live;
  logic        r_armed;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;

  logic        w_rxs;
  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [2:0]  w_idx_next;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_data_next;
  logic        w_valid_next;
  logic        w_ferr_next;

  assign w_rxs = r_sync[1];

  // r_live marks when rxs carries a real line sample rather than the reset
  // value; a start is only accepted once the line has been seen high after that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_live  <= {r_live[0], 1'b1};
      r_armed <= r_armed | (r_live[1] & w_rxs);
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 16'd1;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = 16'd0;
        if (!w_rxs && r_armed) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (r_cnt == C_HALF_M1) begin
          w_cnt_next = 16'd0;
          if (!w_rxs) begin
            w_state_next = S_DATA;
            w_idx_next   = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (r_cnt == C_FULL_M1) begin
          w_cnt_next          = 16'd0;
          w_shift_next[r_idx] = w_rxs;
          if (r_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (r_cnt == C_FULL_M1) begin
          w_cnt_next = 16'd0;
          if (w_rxs) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end
      end

      // A held-low line (break) is swallowed here instead of yielding 0x00 frames.
      S_WAIT_HIGH: begin
        w_cnt_next = 16'd0;
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_cnt_next   = 16'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural transmitter queues the expected outcome of
// each frame; a monitor pops and checks whenever a pulse appears.
`timescale 1ns/100ps
module tb_uart_rx;

  localparam int N   = 16;
  localparam int LAT = N / 2 + 9 * N + 3;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  exp_t       q[$];
  exp_t       me;
  logic [7:0] model_data = 8'h00;
  bit         pv = 1'b0;
  bit         pf = 1'b0;
  bit         saw;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Ideal transmitter at the nominal bit period; called aligned 1 ns after an edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit track);
    exp_t       e;
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    if (track) begin
      e.is_err = !stop_ok;
      e.d      = b;
      e.cyc    = cyc + LAT;
      q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      cycles(N);
    end
  endtask

  // Transmitter with an off-nominal bit period; arrival time is not checked.
  task automatic send_frame_t(input logic [7:0] b, input real bit_ns);
    exp_t       e;
    logic [9:0] bits;
    bits     = {1'b1, b, 1'b0};
    e.is_err = 1'b0;
    e.d      = b;
    e.cyc    = -1;
    q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      #(bit_ns);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pf = 1'b0;
    end else begin
      if (valid || frame_err) begin
        chk("pulse_exclusive", 32'(valid & frame_err), 32'd0);
        chk("pulse_width", 32'({pv & valid, pf & frame_err}), 32'd0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%02h, expected no pulse (cycle %0d)",
                   valid, frame_err, data, cyc);
        end else begin
          me = q.pop_front();
          $display("txn cycle=%0d %s data=%02h", cyc, frame_err ? "frame_err" : "valid", data);
          chk("pulse_kind", 32'(frame_err), 32'(me.is_err));
          chk("data", 32'(data), me.is_err ? 32'(model_data) : 32'(me.d));
          if (me.cyc >= 0) begin
            total++;
            if (cyc < me.cyc - 2 || cyc > me.cyc + 2) begin
              bad++;
              $display("FAIL pulse_time: got cycle %0d, expected %0d +/-2", cyc, me.cyc);
            end
          end
          if (!me.is_err) model_data = me.d;
        end
      end
      pv = valid;
      pf = frame_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then a quiet idle line
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #11 rst = 1'b0;
    @(posedge clk);
    #1;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      saw |= busy;
    end
    chk("idle_busy", 32'(saw), 32'd0);
    chk("idle_data", 32'(data), 32'h00);

    // 2: single frame
    send_frame(8'hA5, 1'b1, 1'b1);
    cycles(20);

    // 3: back-to-back frames
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    cycles(20);

    // 4: short glitch, then a good frame
    rx  = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      saw |= busy;
    end
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      saw |= busy;
    end
    chk("glitch_busy_seen", 32'(saw), 32'd1);
    chk("glitch_back_idle", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    cycles(20);

    // 5: bad stop bit, line held low, then recovery
    send_frame(8'h81, 1'b0, 1'b1);
    cycles(20);
    chk("break_busy", 32'(busy), 32'd1);
    cycles(20);
    rx = 1'b1;
    cycles(5);
    chk("break_released", 32'(busy), 32'd0);
    cycles(20);
    send_frame(8'h42, 1'b1, 1'b1);
    cycles(20);

    // 6: reset during data bit 4 (line low), released while still low
    fork
      send_frame(8'hE5, 1'b1, 1'b0);
    join_none
    cycles(86);
    rst        = 1'b1;
    model_data = 8'h00;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_pulses", 32'({valid, frame_err}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      saw |= busy;
    end
    chk("after_rst_low_line", 32'(saw), 32'd0);
    cycles(80);
    send_frame(8'hC3, 1'b1, 1'b1);
    cycles(20);

    // random frames with random gaps, then off-nominal baud
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b1);
      cycles(int'($urandom_range(0, 20)));
    end
    send_frame_t(8'($urandom), 155.2);
    cycles(10);
    send_frame_t(8'($urandom), 164.8);
    cycles(10);

    cycles(200);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
